// File: rtl/inst_pre_decode.sv
// Pre-decode stage: 2-entry skid FIFO, output packet register, lane compaction and control-flow marking.
// Optional macro PREDECODE_BRANCH_REDIRECT_EN adds B/BL target prediction, lane truncation and fetch redirect.
module inst_pre_decode #(
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 32
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              FetchAble,
  output logic              FetchReady,
  input  logic [ADDR_W-1:0] FetchPc,
  input  logic [127:0]      FetchDate,
  input  logic              PreStop,
  input  logic              PreFlash,
  output logic              Pre1Able,
  output logic [ADDR_W-1:0] Pre1Addr,
  output logic [31:0]       Pre1Date,
  output logic              Pre1Part,
  output logic [ADDR_W-1:0] Pre1NAdr,
  output logic              Pre2Able,
  output logic [ADDR_W-1:0] Pre2Addr,
  output logic [31:0]       Pre2Date,
  output logic              Pre2Part,
  output logic [ADDR_W-1:0] Pre2NAdr,
  output logic              Pre3Able,
  output logic [ADDR_W-1:0] Pre3Addr,
  output logic [31:0]       Pre3Date,
  output logic              Pre3Part,
  output logic [ADDR_W-1:0] Pre3NAdr,
  output logic              Pre4Able,
  output logic [ADDR_W-1:0] Pre4Addr,
  output logic [31:0]       Pre4Date,
  output logic              Pre4Part,
  output logic [ADDR_W-1:0] Pre4NAdr,
  output logic              RedirectAble,
  output logic [ADDR_W-1:0] RedirectAddr
);

  localparam logic [1:0] DEPTH_C = 2'(FIFO_DEPTH);

  logic [ADDR_W-1:2] fifo_pc_q  [2];
  logic [127:0]      fifo_dat_q [2];
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              out_vld_q, out_vld_d;
  logic [ADDR_W-1:2] out_pc_q;
  logic [127:0]      out_dat_q;
  logic              push, pop, redirect;
  logic [ADDR_W-1:0] redir_addr;
  logic              unused_pc;

  logic [3:0]        lane_able, lane_part;
  logic [ADDR_W-1:0] lane_addr [4];
  logic [ADDR_W-1:0] lane_nadr [4];
  logic [31:0]       lane_inst [4];

  function automatic logic is_cf(input logic [5:0] op);
    return (op >= 6'b010010) && (op <= 6'b011011);
  endfunction

`ifdef PREDECODE_BRANCH_REDIRECT_EN
  function automatic logic is_bbl(input logic [5:0] op);
    return op[5:1] == 5'b01010;
  endfunction

  function automatic logic [ADDR_W-1:0] br_target(input logic [ADDR_W-1:0] pc,
                                                  input logic [25:0] imm);
    logic signed [27:0] offs;
    offs = {imm[9:0], imm[25:10], 2'b00};
    return pc + {{(ADDR_W-28){offs[27]}}, offs};
  endfunction
`endif

  assign unused_pc = ^FetchPc[1:0];

  always_comb begin
    logic [1:0]        sl;
    logic [31:0]       w;
    logic [ADDR_W-1:0] a, n;
    logic              present, cut;
    present    = out_vld_q & ~PreStop & ~PreFlash;
    cut        = 1'b0;
    redirect   = 1'b0;
    redir_addr = '0;
    sl         = '0;
    w          = '0;
    a          = '0;
    n          = '0;
    for (int i = 0; i < 4; i++) begin
      sl = out_pc_q[3:2] + 2'(i);
      w  = out_dat_q[{sl, 5'd0} +: 32];
      a  = {out_pc_q[ADDR_W-1:4], sl, 2'b00};
      n  = a + ADDR_W'(4);
`ifdef PREDECODE_BRANCH_REDIRECT_EN
      if (is_bbl(w[31:26])) n = br_target(a, w[25:0]);
`endif
      lane_able[i] = present & (({1'b0, out_pc_q[3:2]} + 3'(i)) <= 3'd3) & ~cut;
`ifdef PREDECODE_BRANCH_REDIRECT_EN
      // First taken-looking B/BL ends the packet; younger lanes are wrong-path.
      if (lane_able[i] && is_bbl(w[31:26]) && (n != a + ADDR_W'(4))) begin
        cut        = 1'b1;
        redirect   = 1'b1;
        redir_addr = n;
      end
`endif
      lane_addr[i] = lane_able[i] ? a : '0;
      lane_inst[i] = lane_able[i] ? w : '0;
      lane_nadr[i] = lane_able[i] ? n : '0;
      lane_part[i] = lane_able[i] & is_cf(w[31:26]);
    end
  end

  always_comb begin
    FetchReady = (cnt_q != DEPTH_C) & ~PreFlash & ~redirect;
    push       = FetchAble & FetchReady;
    pop        = ~PreStop & ~PreFlash & ~redirect & (cnt_q != 2'd0);
    wr_ptr_d   = wr_ptr_q ^ push;
    rd_ptr_d   = rd_ptr_q ^ pop;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    out_vld_d  = PreStop ? out_vld_q : (cnt_q != 2'd0);
    if (PreFlash | redirect) begin
      wr_ptr_d  = 1'b0;
      rd_ptr_d  = 1'b0;
      cnt_d     = 2'd0;
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
      out_vld_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      out_vld_q <= out_vld_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= FetchPc[ADDR_W-1:2];
      fifo_dat_q[wr_ptr_q] <= FetchDate;
    end
    if (pop) begin
      out_pc_q  <= fifo_pc_q[rd_ptr_q];
      out_dat_q <= fifo_dat_q[rd_ptr_q];
    end
  end

  assign Pre1Able = lane_able[0];
  assign Pre1Addr = lane_addr[0];
  assign Pre1Date = lane_inst[0];
  assign Pre1Part = lane_part[0];
  assign Pre1NAdr = lane_nadr[0];
  assign Pre2Able = lane_able[1];
  assign Pre2Addr = lane_addr[1];
  assign Pre2Date = lane_inst[1];
  assign Pre2Part = lane_part[1];
  assign Pre2NAdr = lane_nadr[1];
  assign Pre3Able = lane_able[2];
  assign Pre3Addr = lane_addr[2];
  assign Pre3Date = lane_inst[2];
  assign Pre3Part = lane_part[2];
  assign Pre3NAdr = lane_nadr[2];
  assign Pre4Able = lane_able[3];
  assign Pre4Addr = lane_addr[3];
  assign Pre4Date = lane_inst[3];
  assign Pre4Part = lane_part[3];
  assign Pre4NAdr = lane_nadr[3];

  assign RedirectAble = redirect;
  assign RedirectAddr = redir_addr;

endmodule

// File: tb/tb_inst_pre_decode.sv
// Bench for inst_pre_decode: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based behavioural model.
module tb_inst_pre_decode;

  localparam logic [31:0] NOP = 32'h03400000;

  logic         Clk = 1'b0, Rest = 1'b0, FetchAble = 1'b0, PreStop = 1'b0, PreFlash = 1'b0;
  logic [31:0]  FetchPc = '0;
  logic [127:0] FetchDate = '0;
  logic         FetchReady, RedirectAble;
  logic [31:0]  RedirectAddr;
  logic         Pre1Able, Pre2Able, Pre3Able, Pre4Able;
  logic         Pre1Part, Pre2Part, Pre3Part, Pre4Part;
  logic [31:0]  Pre1Addr, Pre2Addr, Pre3Addr, Pre4Addr;
  logic [31:0]  Pre1Date, Pre2Date, Pre3Date, Pre4Date;
  logic [31:0]  Pre1NAdr, Pre2NAdr, Pre3NAdr, Pre4NAdr;

  inst_pre_decode dut (
    .Clk(Clk), .Rest(Rest), .FetchAble(FetchAble), .FetchReady(FetchReady),
    .FetchPc(FetchPc), .FetchDate(FetchDate), .PreStop(PreStop), .PreFlash(PreFlash),
    .Pre1Able(Pre1Able), .Pre1Addr(Pre1Addr), .Pre1Date(Pre1Date), .Pre1Part(Pre1Part), .Pre1NAdr(Pre1NAdr),
    .Pre2Able(Pre2Able), .Pre2Addr(Pre2Addr), .Pre2Date(Pre2Date), .Pre2Part(Pre2Part), .Pre2NAdr(Pre2NAdr),
    .Pre3Able(Pre3Able), .Pre3Addr(Pre3Addr), .Pre3Date(Pre3Date), .Pre3Part(Pre3Part), .Pre3NAdr(Pre3NAdr),
    .Pre4Able(Pre4Able), .Pre4Addr(Pre4Addr), .Pre4Date(Pre4Date), .Pre4Part(Pre4Part), .Pre4NAdr(Pre4NAdr),
    .RedirectAble(RedirectAble), .RedirectAddr(RedirectAddr)
  );

  always #5 Clk = ~Clk;

  logic [3:0]  d_able, d_part;
  logic [31:0] d_addr [4];
  logic [31:0] d_date [4];
  logic [31:0] d_nadr [4];
  assign d_able = {Pre4Able, Pre3Able, Pre2Able, Pre1Able};
  assign d_part = {Pre4Part, Pre3Part, Pre2Part, Pre1Part};
  assign d_addr[0] = Pre1Addr; assign d_addr[1] = Pre2Addr; assign d_addr[2] = Pre3Addr; assign d_addr[3] = Pre4Addr;
  assign d_date[0] = Pre1Date; assign d_date[1] = Pre2Date; assign d_date[2] = Pre3Date; assign d_date[3] = Pre4Date;
  assign d_nadr[0] = Pre1NAdr; assign d_nadr[1] = Pre2NAdr; assign d_nadr[2] = Pre3NAdr; assign d_nadr[3] = Pre4NAdr;

  int tests = 0, fails = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct packed { logic [31:0] pc; logic [127:0] d; } pkt_t;
  pkt_t mq[$];
  pkt_t m_out;
  bit   m_ov = 0;
  bit   e_redir = 0, e_ready = 1;

  function automatic int br_offs(logic [31:0] inst);
    int o;
    o = int'({inst[9:0], inst[25:10]});
    if (o >= (1 << 25)) o -= (1 << 26);
    return o * 4;
  endfunction

  always @(negedge Clk) begin
    int off, n, trig;
    bit present, ea;
    logic [31:0] ad [4];
    logic [31:0] in [4];
    logic [31:0] na [4];
    logic [31:0] raddr;
    off = int'(m_out.pc[3:2]);
    n = m_ov ? 4 - off : 0;
    present = Rest && m_ov && !PreStop && !PreFlash;
    trig = 4;
    e_redir = 0;
    raddr = '0;
    for (int i = 0; i < 4; i++) begin
      ad[i] = {m_out.pc[31:4], 4'b0} + 32'(4 * (off + i));
      in[i] = (i < n) ? m_out.d[32*(off+i) +: 32] : '0;
      na[i] = ad[i] + 32'd4;
`ifdef PREDECODE_BRANCH_REDIRECT_EN
      if (in[i][31:26] == 6'd20 || in[i][31:26] == 6'd21) na[i] = ad[i] + 32'(br_offs(in[i]));
      if (present && i < n && trig == 4 && (in[i][31:26] == 6'd20 || in[i][31:26] == 6'd21)
          && na[i] != ad[i] + 32'd4) begin
        trig = i;
        e_redir = 1;
        raddr = na[i];
      end
`endif
    end
    e_ready = !Rest || (mq.size() < 2 && !PreFlash && !e_redir);
    chk("ready", 32'(FetchReady), 32'(e_ready));
    chk("redir_able", 32'(RedirectAble), 32'(e_redir));
`ifdef PREDECODE_BRANCH_REDIRECT_EN
    if (e_redir || !Rest) chk("redir_addr", RedirectAddr, raddr);
`else
    chk("redir_addr", RedirectAddr, 32'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      ea = present && (i < n) && (i <= trig);
      chk($sformatf("able%0d", i + 1), 32'(d_able[i]), 32'(ea));
      if (ea) begin
        chk($sformatf("addr%0d", i + 1), d_addr[i], ad[i]);
        chk($sformatf("date%0d", i + 1), d_date[i], in[i]);
        chk($sformatf("part%0d", i + 1), 32'(d_part[i]),
            32'(in[i][31:26] >= 6'd18 && in[i][31:26] <= 6'd27));
        chk($sformatf("nadr%0d", i + 1), d_nadr[i], na[i]);
      end else if (i >= n) begin
        chk($sformatf("zero%0d", i + 1), d_addr[i] | d_date[i] | d_nadr[i] | 32'(d_part[i]), 32'd0);
      end
    end
  end

  always @(posedge Clk or negedge Rest) begin
    bit push;
    if (!Rest) begin
      mq.delete();
      m_ov = 0;
    end else if (PreFlash || e_redir) begin
      mq.delete();
      m_ov = 0;
    end else begin
      push = FetchAble && e_ready;
      if (!PreStop) begin
        if (mq.size() > 0) begin
          m_out = mq.pop_front();
          m_ov = 1;
        end else m_ov = 0;
      end
      if (push) mq.push_back({FetchPc, FetchDate});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(int c);
    FetchAble = 0; PreStop = 0; PreFlash = 0;
    repeat (c) tick();
  endtask

  task automatic send(logic [31:0] pc, logic [127:0] d);
    FetchAble = 1; FetchPc = pc; FetchDate = d;
    tick();
    FetchAble = 0;
  endtask

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom % 8)
      0, 1: r[31:26] = 6'($urandom_range(0, 17));
      2: r[31:26] = 6'd20;
      3: r[31:26] = 6'd21;
      4: r = ($urandom % 2 == 0) ? 32'h50000400 : 32'h54000400;
      5: r[31:26] = 6'($urandom_range(18, 27));
      default: ;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] pcs [3];
    logic [31:0] seen_pc [8];
    int seen_cyc [8];
    int k, ns;
    bit acc;
    pcs[0] = 32'h1C000100; pcs[1] = 32'h1C000110; pcs[2] = 32'h1C000120;

    // reset
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", 32'(FetchReady), 32'd1);
    chk("rst_able", 32'(d_able), 32'd0);
    chk("rst_redir", 32'(RedirectAble), 32'd0);
    @(posedge Clk); #1 Rest = 1;

    // basic
    send(32'h1C000000, {4{NOP}});
    tick();
    @(negedge Clk);
    chk("basic_able", 32'(d_able), 32'hF);
    chk("basic_addr1", Pre1Addr, 32'h1C000000);
    chk("basic_addr4", Pre4Addr, 32'h1C00000C);
    chk("basic_nadr3", Pre3NAdr, 32'h1C00000C);
    chk("basic_part", 32'(d_part), 32'd0);
    tick();

    // offset compaction
    idle(3);
    send(32'h1C000018, {32'hBBBB0000, 32'hAAAA0000, 32'h11111111, 32'h22222222});
    tick();
    @(negedge Clk);
    chk("off_able", 32'(d_able), 32'h3);
    chk("off_addr1", Pre1Addr, 32'h1C000018);
    chk("off_date1", Pre1Date, 32'hAAAA0000);
    chk("off_addr2", Pre2Addr, 32'h1C00001C);
    chk("off_date2", Pre2Date, 32'hBBBB0000);
    chk("off_addr3", Pre3Addr, 32'h0);
    tick();

    // backpressure
    idle(3);
    k = 0; ns = 0;
    for (int c = 0; c < 16; c++) begin
      PreStop = (c < 5);
      FetchAble = (k < 3);
      if (k < 3) begin FetchPc = pcs[k]; FetchDate = {4{NOP}}; end
      @(negedge Clk);
      if (c < 5) chk("bp_stop_able", 32'(d_able), 32'd0);
      if (c == 2) chk("bp_full_ready", 32'(FetchReady), 32'd0);
      acc = FetchAble && FetchReady;
      if (Pre1Able && ns < 8) begin seen_pc[ns] = Pre1Addr; seen_cyc[ns] = c; ns++; end
      tick();
      if (acc) k++;
    end
    FetchAble = 0;
    chk("bp_count", 32'(ns), 32'd3);
    for (int j = 0; j < 3; j++) begin
      if (j < ns) begin
        chk("bp_order", seen_pc[j], pcs[j]);
        chk("bp_consec", 32'(seen_cyc[j] - seen_cyc[0]), 32'(j));
      end
    end

    // branch at slot 1, followed by a second beat
    idle(3);
    send(32'h1C000000, {NOP, NOP, 32'h50004000, NOP});
    send(32'h1C000010, {4{NOP}});
    @(negedge Clk);
`ifdef PREDECODE_BRANCH_REDIRECT_EN
    chk("br_able", 32'(d_able), 32'h3);
    chk("br_part2", 32'(Pre2Part), 32'd1);
    chk("br_nadr2", Pre2NAdr, 32'h1C000044);
    chk("br_redir", 32'(RedirectAble), 32'd1);
    chk("br_redir_addr", RedirectAddr, 32'h1C000044);
    chk("br_ready", 32'(FetchReady), 32'd0);
    for (int j = 0; j < 4; j++) begin
      tick();
      @(negedge Clk);
      chk("br_after_redir", 32'(RedirectAble), 32'd0);
      chk("br_drop", 32'(d_able), 32'd0);
    end
`else
    chk("nb_able", 32'(d_able), 32'hF);
    chk("nb_part2", 32'(Pre2Part), 32'd1);
    chk("nb_nadr2", Pre2NAdr, 32'h1C000008);
    chk("nb_redir", 32'(RedirectAble), 32'd0);
    tick();
    @(negedge Clk);
    chk("nb_second", Pre1Addr, 32'h1C000010);
    chk("nb_redir2", 32'(RedirectAble), 32'd0);
`endif
    tick();

    // flush with two buffered and OutValid
    idle(3);
    send(32'h1C000200, {4{NOP}});
    send(32'h1C000210, {4{NOP}});
    PreStop = 1;
    send(32'h1C000220, {4{NOP}});
    PreFlash = 1; FetchAble = 1; FetchPc = 32'h1C000230;
    @(negedge Clk);
    chk("fl_ready", 32'(FetchReady), 32'd0);
    chk("fl_able", 32'(d_able), 32'd0);
    chk("fl_redir", 32'(RedirectAble), 32'd0);
    tick();
    PreFlash = 0; PreStop = 0; FetchAble = 0;
    @(negedge Clk);
    chk("fl_after_able", 32'(d_able), 32'd0);
    chk("fl_after_ready", 32'(FetchReady), 32'd1);
    tick();
    @(negedge Clk);
    chk("fl_empty", 32'(d_able), 32'd0);
    tick();

    // randomized traffic with a mid-run reset
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        PreFlash = 0;
        Rest = 0;
        repeat (3) tick();
        Rest = 1;
      end
      FetchAble = ($urandom % 4) != 0;
      PreStop   = ($urandom % 4) == 0;
      PreFlash  = ($urandom % 32) == 0;
      if ($urandom % 10 == 0) FetchPc = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      else FetchPc = 32'h1C000000 + 32'($urandom_range(0, 4095) << 4) + 32'($urandom_range(0, 15));
      FetchDate = {rnd_inst(), rnd_inst(), rnd_inst(), rnd_inst()};
      tick();
    end
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_pre_decode.md
# inst_pre_decode

- Front-end stage between the instruction fetch return path and the four-lane instruction issue queue.
- Accepts one 128-bit aligned fetch packet per cycle, holding 1–4 valid instructions selected by the start PC.
- Buffers packets in a 2-entry skid FIFO, compacts the valid instructions onto lanes 1..n, and marks control-flow instructions.
- Computes each instruction's predicted next address and redirects fetch on direct unconditional branches.

## Interface

Parameters:
- FIFO_DEPTH, 2, skid-FIFO entries. Fixed at 2; other values are unsupported.
- ADDR_W, 32, address width.

Ports:
- Clk  in  1  clock.
- Rest  in  1  reset, asynchronous, active-low.
- FetchAble  in  1  fetch packet valid.
- FetchReady  out  1  FIFO can accept a packet; a beat transfers when FetchAble & FetchReady.
- FetchPc  in  32  PC of the first valid instruction. [3:2] is the slot offset; [1:0] is ignored.
- FetchDate  in  128  packet; slot k occupies bits [32k+31:32k].
- PreStop  in  1  downstream stop (issue-queue full or ctrl stall).
- PreFlash  in  1  synchronous flush.
- Pre{1..4}Able  out  1  lane valid; lanes are always contiguous from lane 1.
- Pre{1..4}Addr  out  32  instruction PC.
- Pre{1..4}Date  out  32  instruction word.
- Pre{1..4}Part  out  1  control-flow marker.
- Pre{1..4}NAdr  out  32  predicted next PC.
- RedirectAble  out  1  one-cycle fetch redirect pulse.
- RedirectAddr  out  32  redirect target.

## Operation

- **Skid FIFO.** Two-entry circular FIFO of {FetchPc, FetchDate}.
  - FetchReady = FIFO count < 2.
  - Simultaneous push and pop at count 2 is not allowed; FetchReady is already 0.
- **Output register.** Holds one packet (OutValid, PC, data).
  - When PreStop=0 it loads the FIFO head, or clears OutValid if the FIFO is empty.
  - When PreStop=1 it holds.
- **Lane enables.** Pre*Able = OutValid & ~PreStop & lane-populated.
  - The issue queue writes on Able alone, so every packet is presented exactly once.
- **Compaction.** With off = PC[3:2], n = 4 − off.
  - Lane i (i = 1..n) carries slot off+i−1.
  - Addr = {PC[31:4], 4'b0} + 4·(off+i−1).
  - Lanes n+1..4: Able=0; Addr/Date/NAdr = 0; Part=0.
- **Part.** Part = 1 when inst[31:26] is in 6'b010010..6'b011011 (BCEQZ/BCNEZ, JIRL, B, BL, BEQ..BGEU).
- **NAdr.**
  - Default: Addr + 4.
  - For B (010100) and BL (010101), when the macro is enabled: Addr + sext({inst[9:0], inst[25:10], 2'b00}), with 32-bit wrap.
- **Redirect** (macro enabled).
  - Trigger: the lowest lane holding B/BL whose NAdr ≠ Addr+4.
  - Lanes after it are Able=0.
  - RedirectAble = 1 and RedirectAddr = that NAdr, in the same cycle the lanes are presented.
  - In that cycle the FIFO is cleared, any incoming fetch beat is dropped (FetchReady forced 0), and the output register loads nothing (OutValid ← 0).
- **Flush.** PreFlash=1 clears the FIFO and OutValid at the next edge.
  - In the flush cycle: FetchReady=0, all Able=0, RedirectAble=0.
  - PreFlash has priority over PreStop and redirect.
- **Reset.** FIFO pointers/count = 0, OutValid = 0.
  - All outputs 0 except FetchReady = 1.
  - Reset asserted mid-transfer drops all buffered packets.

## Timing

- Latency: a beat accepted at edge N, with the FIFO empty and PreStop=0, is loaded into the output register at edge N+1. Its lanes are presented in cycle N+1.
- Throughput: one packet per cycle with PreStop=0.
- PreStop raised: lanes drop combinationally the same cycle and the packet is held. The FIFO fills; FetchReady falls once count = 2.
- PreStop falling: the held packet is presented in that same cycle.
- RedirectAble is high for exactly one cycle per redirecting packet. It never asserts while PreStop=1 or PreFlash=1.

## Configuration

- Macro: PREDECODE_BRANCH_REDIRECT_EN.
- Defined: B/BL target computation, lane truncation, RedirectAble/RedirectAddr and wrong-path drop as described above.
- Undefined:
  - NAdr = Addr + 4 for every lane.
  - RedirectAble and RedirectAddr tied 0; no truncation or drop.
  - Part generation is unchanged.

## Test plan

- **Reset/basic.**
  - Stimulus: after reset, one beat with PC=0x1C000000 and four NOPs (0x03400000).
  - Required response: next cycle Pre1..4Able=1; Addr = 0x1C000000/04/08/0C; NAdr = Addr+4; Part=0.
- **Offset compaction.**
  - Stimulus: PC=0x1C000018, slots 2–3 hold 0xAAAA0000 and 0xBBBB0000.
  - Required response: Pre1/Pre2 carry 0x1C000018/0x1C00001C with those words; Pre3/4Able=0.
- **Backpressure.**
  - Stimulus: PreStop=1 for 5 cycles while fetch streams 3 packets.
  - Required response: all Able=0 during the stop; FetchReady low after 2 buffered; on release the three packets appear on three consecutive cycles, none duplicated or lost.
- **Branch redirect** (macro on).
  - Stimulus: PC=0x1C000000, slot1 = B with offs=+0x40 (0x50004000), followed by a second beat.
  - Required response:
    - Pre1/Pre2 Able=1; Pre2Part=1; Pre2NAdr=0x1C000044.
    - Pre3/4Able=0; RedirectAble=1 for one cycle with RedirectAddr=0x1C000044.
    - The second beat is never presented.
- **Flush.**
  - Stimulus: PreFlash=1 with 2 packets buffered and OutValid=1.
  - Required response: next cycle all Able=0, FIFO empty, FetchReady=1.
- **Macro off.**
  - Stimulus: the same packet as the branch-redirect test.
  - Required response: all four lanes valid; Pre2NAdr=0x1C000008; RedirectAble stays 0.
